mdu_seq: RTL and testbench



---
 rtl/mdu_seq.sv | 153 +++++++++++++++
 tb/tb_mdu_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Sequential RISC-V M-extension multiply/divide unit.
// Shift-add multiplier and restoring divider, one bit per cycle, fixed N+1 cycle latency.
module mdu_seq #(
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [2:0]   i_op,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_result,
    output logic         o_zero
);

    localparam int CW = $clog2(N);
    localparam logic [N-1:0]   ONE_N   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0] ONE_2N  = {{(2*N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]   MIN_N   = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0]  LAST    = CW'(N-1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic [N-1:0]  r_result;

    logic [2:0]    r_op;
    logic          r_neg_a;
    logic          r_neg_b;
    logic          r_divz;
    logic          r_ovf;
    logic [N-1:0]  r_hi;
    logic [N-1:0]  r_lo;
    logic [N-1:0]  r_opb;
    logic [N-1:0]  r_a;

    function automatic logic [N-1:0] neg_n(input logic [N-1:0] v, input logic en);
        return en ? (~v + ONE_N) : v;
    endfunction

    function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v, input logic en);
        return en ? (~v + ONE_2N) : v;
    endfunction

    logic         w_sgn_a;
    logic         w_sgn_b;
    logic         w_neg_a;
    logic         w_neg_b;
    logic         w_is_sdiv;
    logic [N:0]   w_sum;
    logic [N:0]   w_madd;
    logic [N:0]   w_shl;
    logic [N:0]   w_diff;
    logic [2*N-1:0] w_prod;
    logic [N-1:0] w_quo;
    logic [N-1:0] w_rem;
    logic [N-1:0] w_res;

    // MUL only uses the low half, which is the same for any signedness.
    assign w_is_sdiv = (i_op == 3'b100) || (i_op == 3'b110);
    assign w_sgn_a   = (i_op == 3'b001) || (i_op == 3'b010) || w_is_sdiv;
    assign w_sgn_b   = (i_op == 3'b001) || w_is_sdiv;
    assign w_neg_a   = w_sgn_a & i_a[N-1];
    assign w_neg_b   = w_sgn_b & i_b[N-1];

    assign w_sum  = {1'b0, r_hi} + {1'b0, r_opb};
    assign w_madd = r_lo[0] ? w_sum : {1'b0, r_hi};
    assign w_shl  = {r_hi, r_lo[N-1]};
    assign w_diff = w_shl - {1'b0, r_opb};

    assign w_prod = neg_2n({r_hi, r_lo}, r_neg_a ^ r_neg_b);
    assign w_quo  = neg_n(r_lo, r_neg_a ^ r_neg_b);
    assign w_rem  = neg_n(r_hi, r_neg_a);

    always_comb begin
        w_res = '0;
        if (!r_op[2]) begin
            w_res = (r_op[1:0] == 2'b00) ? w_prod[N-1:0] : w_prod[2*N-1:N];
        end else if (!r_op[1]) begin
            w_res = r_divz ? '1 : (r_ovf ? MIN_N : w_quo);
        end else begin
            w_res = r_divz ? r_a : (r_ovf ? '0 : w_rem);
        end
    end

    // Working registers: r_hi:r_lo is the product accumulator or remainder:quotient pair.
    always_ff @(posedge i_clk) begin
        if (r_state == IDLE && i_start) begin
            r_op    <= i_op;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_divz  <= (i_b == '0);
            r_ovf   <= w_is_sdiv && (i_a == MIN_N) && (i_b == '1);
            r_a     <= i_a;
            r_hi    <= '0;
            r_lo    <= neg_n(i_a, w_neg_a);
            r_opb   <= neg_n(i_b, w_neg_b);
        end else if (r_state == CALC) begin
            if (!r_op[2]) begin
                {r_hi, r_lo} <= {w_madd, r_lo[N-1:1]};
            end else if (!w_diff[N]) begin
                r_hi <= w_diff[N-1:0];
                r_lo <= {r_lo[N-2:0], 1'b1};
            end else begin
                r_hi <= w_shl[N-1:0];
                r_lo <= {r_lo[N-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_cnt   <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                FIX: begin
                    r_result <= w_res;
                    r_done   <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy   = (r_state != IDLE);
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_zero   = (r_result == '0);

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq (N=32): latency, results, special cases, held START, async reset.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;

    int total = 0;
    int bad   = 0;
    int lat;

    mdu_seq #(.N(32)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .o_busy   (busy),
        .o_done   (done),
        .o_result (result),
        .o_zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp);
        int n;
        int bc;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
        n = 0; bc = 0;
        while (!done && n < 60) begin
            if (busy) bc++;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd33);
        chk({tag, " busy_cycles"}, 64'(bc), 64'd33);
        chk({tag, " result"}, 64'(result), 64'(exp));
        chk({tag, " zero"}, 64'(zero), 64'(exp == 32'h0));
        chk({tag, " busy_in_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        chk("reset zero", 64'(zero), 64'd1);
        @(negedge clk) rst_n = 1'b1;

        run_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
        @(posedge clk); #1;
        chk("done pulse drops", 64'(done), 64'd0);

        run_op("MULH min*min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("MULHSU min*min", 3'b010, 32'h80000000, 32'h80000000, 32'hC0000000);
        run_op("MULHU min*min",  3'b011, 32'h80000000, 32'h80000000, 32'h40000000);
        run_op("DIV -7/2",       3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run_op("REM -7/2",       3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run_op("DIVU 100/7",     3'b101, 32'd100, 32'd7, 32'd14);
        run_op("REMU 100/7",     3'b111, 32'd100, 32'd7, 32'd2);
        run_op("DIV 5/0",        3'b100, 32'd5, 32'd0, 32'hFFFFFFFF);
        run_op("REM 5/0",        3'b110, 32'd5, 32'd0, 32'd5);
        run_op("DIVU 5/0",       3'b101, 32'd5, 32'd0, 32'hFFFFFFFF);
        run_op("REMU 5/0",       3'b111, 32'd5, 32'd0, 32'd5);
        run_op("DIV ovf",        3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_op("REM ovf",        3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0);
        run_op("DIV 7/-2",       3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
        run_op("REM 7/-2",       3'b110, 32'd7, 32'hFFFFFFFE, 32'd1);
        run_op("DIV min/1",      3'b100, 32'h80000000, 32'd1, 32'h80000000);
        run_op("MULHU -1*-1",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("MULH -1*-1",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
        run_op("MULHSU -1*max",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("MUL x*0",        3'b000, 32'h12345678, 32'd0, 32'h0);
        run_op("MUL max*max",    3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001);
        run_op("MULH max*max",   3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF);
        run_op("DIVU max/1",     3'b101, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF);
        run_op("REMU max/16",    3'b111, 32'hFFFFFFFF, 32'd16, 32'd15);

        // START held high with operands churning; second op accepted in the DONE cycle.
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        lat = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        chk("held first latency", 64'(lat), 64'd33);
        chk("held first result", 64'(result), 64'd15);
        @(negedge clk);
        a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        chk("held second accepted", 64'(busy), 64'd1);
        chk("held done dropped", 64'(done), 64'd0);
        start = 1'b0; a = $urandom; b = $urandom;
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("held second latency", 64'(lat), 64'd33);
        chk("held second result", 64'(result), 64'd42);

        // Asynchronous abort in the middle of a divide.
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort result", 64'(result), 64'd0);
        chk("abort zero", 64'(zero), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        lat = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) lat++;
        end
        chk("abort no done", 64'(lat), 64'd0);
        run_op("MUL 3*4 after abort", 3'b000, 32'd3, 32'd4, 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
